clk_gat_ctrl: RTL and testbench

Clock-gating controller that generates the enable consumed by the integrated clock gate (int_clk_gat `en` input). It watches downstream activity and deasserts the gate enable after a programmable run of idle cycles. On a wake request it re-enables the clock and asserts ready only after a settle period. Sits in the always-on clock domain, upstream of the ICG, one per gated region.

---
 rtl/clk_gat_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_gat_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_gat_ctrl.sv
// rtl/clk_gat_ctrl.sv - clock-gate enable controller with idle detection and wake settle
// All outputs come straight from flops so gate_en is glitch-free into the ICG latch.
module clk_gat_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int GCNT_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              busy_in,
    input  logic              wake_req,
    input  logic              force_on,
    output logic              gate_en,
    output logic              ready,
    output logic              gated,
    output logic [GCNT_W-1:0] gate_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_MAX  = '1;

    state_t            state_q;
    logic [CNT_W-1:0]  idle_cnt_q;
    logic [CNT_W-1:0]  wake_cnt_q;
    logic [GCNT_W-1:0] gate_cnt_q;
    logic [GCNT_W-1:0] gate_cnt_d;
    logic              gate_en_q;
    logic              ready_q;
    logic              gated_q;
    logic              quiet;

    assign quiet = !busy_in && !wake_req && !force_on;

    // Saturating event count: the value loaded on every entry into GATED.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if (gate_cnt_q != GCNT_MAX) begin
            gate_cnt_d = gate_cnt_q + GCNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            ready_q    <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (quiet) begin
                        if (IDLE_CYCLES == 1) begin
                            state_q    <= GATED;
                            idle_cnt_q <= '0;
                            gate_cnt_q <= gate_cnt_d;
                            gate_en_q  <= 1'b0;
                            ready_q    <= 1'b0;
                            gated_q    <= 1'b1;
                        end else begin
                            state_q    <= IDLE_WAIT;
                            idle_cnt_q <= CNT_ONE;
                        end
                    end
                end
                IDLE_WAIT: begin
                    // Any activity restarts the idle run from scratch.
                    if (!quiet) begin
                        state_q    <= RUN;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_q    <= GATED;
                        idle_cnt_q <= '0;
                        gate_cnt_q <= gate_cnt_d;
                        gate_en_q  <= 1'b0;
                        ready_q    <= 1'b0;
                        gated_q    <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_ONE;
                    end
                end
                GATED: begin
                    if (wake_req || force_on) begin
                        state_q    <= WAKE;
                        wake_cnt_q <= '0;
                        gate_en_q  <= 1'b1;
                        gated_q    <= 1'b0;
                    end
                end
                WAKE: begin
                    // Settle period runs to completion regardless of inputs.
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_q    <= RUN;
                        wake_cnt_q <= '0;
                        ready_q    <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    idle_cnt_q <= '0;
                    wake_cnt_q <= '0;
                    gate_en_q  <= 1'b1;
                    ready_q    <= 1'b1;
                    gated_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gate_en  = gate_en_q;
    assign ready    = ready_q;
    assign gated    = gated_q;
    assign gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_clk_gat_ctrl.sv
// tb/tb_clk_gat_ctrl.sv - self-checking bench for clk_gat_ctrl against a behavioural model
module tb_clk_gat_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;
    localparam int CNT_W       = 8;
    localparam int GCNT_W      = 2;
    localparam int GCNT_MAX    = (1 << GCNT_W) - 1;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              busy_in = 1'b0;
    logic              wake_req = 1'b0;
    logic              force_on = 1'b0;
    logic              gate_en;
    logic              ready;
    logic              gated;
    logic [GCNT_W-1:0] gate_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: clock is off (m_off), or settling with m_settle cycles left,
    // or running with m_streak consecutive quiet samples seen.
    bit m_off    = 1'b0;
    int m_settle = 0;
    int m_streak = 0;
    int m_events = 0;

    clk_gat_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES),
        .CNT_W      (CNT_W),
        .GCNT_W     (GCNT_W)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .busy_in (busy_in),
        .wake_req(wake_req),
        .force_on(force_on),
        .gate_en (gate_en),
        .ready   (ready),
        .gated   (gated),
        .gate_cnt(gate_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        if (rst) begin
            m_off    <= 1'b0;
            m_settle <= 0;
            m_streak <= 0;
            m_events <= 0;
        end else if (m_off) begin
            if (wake_req || force_on) begin
                m_off    <= 1'b0;
                m_settle <= WAKE_CYCLES;
            end
        end else if (m_settle > 0) begin
            m_settle <= m_settle - 1;
        end else if (!busy_in && !wake_req && !force_on) begin
            if (m_streak + 1 >= IDLE_CYCLES) begin
                m_off    <= 1'b1;
                m_streak <= 0;
                m_events <= (m_events < GCNT_MAX) ? m_events + 1 : GCNT_MAX;
            end else begin
                m_streak <= m_streak + 1;
            end
        end else begin
            m_streak <= 0;
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("model_gate_en", int'(gate_en), int'(!m_off));
            check("model_ready", int'(ready), int'(!m_off && m_settle == 0));
            check("model_gated", int'(gated), int'(m_off));
            check("model_gate_cnt", int'(gate_cnt), m_events);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic gate_now(input int exp_cnt);
        busy_in  = 1'b0;
        wake_req = 1'b0;
        force_on = 1'b0;
        for (int i = 0; i < IDLE_CYCLES - 1; i++) begin
            tick();
            check("idle_gate_en_hold", int'(gate_en), 1);
        end
        tick();
        check("gated_gate_en", int'(gate_en), 0);
        check("gated_ready", int'(ready), 0);
        check("gated_flag", int'(gated), 1);
        check("gated_cnt", int'(gate_cnt), exp_cnt);
    endtask

    task automatic wake_up();
        busy_in  = 1'b1;
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        check("wake_gate_en", int'(gate_en), 1);
        check("wake_gated", int'(gated), 0);
        check("wake_ready_j", int'(ready), 0);
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        check("wake_ready_j1", int'(ready), 0);
        tick();
        check("wake_ready_j2", int'(ready), 1);
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        check("rst_gate_en", int'(gate_en), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_gated", int'(gated), 0);
        check("rst_cnt", int'(gate_cnt), 0);
        tick();
        check("rst2_gate_en", int'(gate_en), 1);
        check("rst2_cnt", int'(gate_cnt), 0);

        rst      = 1'b0;
        force_on = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("force_gate_en", int'(gate_en), 1);
        end
        check("force_cnt", int'(gate_cnt), 0);

        force_on = 1'b0;
        busy_in  = 1'b1;
        tick();
        gate_now(1);
        wake_up();

        busy_in = 1'b0;
        repeat (3) tick();
        busy_in = 1'b1;
        tick();
        check("interrupt_gate_en", int'(gate_en), 1);
        gate_now(2);

        force_on = 1'b1;
        tick();
        check("fwake_gate_en", int'(gate_en), 1);
        check("fwake_ready_j", int'(ready), 0);
        tick();
        check("fwake_ready_j1", int'(ready), 0);
        tick();
        check("fwake_ready_j2", int'(ready), 1);
        tick();
        check("fwake_hold", int'(gate_en), 1);

        gate_now(3);
        wake_up();
        gate_now(3);

        busy_in  = 1'b0;
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midwake_rst_gate_en", int'(gate_en), 1);
        check("midwake_rst_ready", int'(ready), 1);
        check("midwake_rst_gated", int'(gated), 0);
        check("midwake_rst_cnt", int'(gate_cnt), 0);

        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            busy_in  = ($urandom_range(0, 3) == 0);
            wake_req = ($urandom_range(0, 19) == 0);
            force_on = ($urandom_range(0, 99) == 0);
            tick();
        end

        @(negedge clk_in);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
